// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmit scheduler:
//                framing state encoding, byte width, line settings and the
//                even-parity helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int BYTE_W    = 8;
  localparam int STOP_BITS = 1;
  localparam int CLK_HZ    = 50_000_000;
  localparam int BAUD      = 9600;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    GAP    = 3'd5
  } state_e;

  // Even parity: the extra bit makes the total count of ones even.
  function automatic logic even_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Picks the first asserted
//                request at or above ptr, wrapping modulo N_REQ.
//  Revision    : 1.0  initial release
//  Ports       : req       in  N_REQ   request vector
//                ptr       in  IDX_W   highest-priority index this round
//                grant     out N_REQ   one-hot grant (all zero if no request)
//                grant_idx out IDX_W   binary index of the grant
//                valid     out 1       any request present
// ============================================================================
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  // Scan offsets from farthest to nearest so the nearest requester above ptr
  // is the last (and therefore winning) assignment.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
        valid     = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched
//  Description : Shares one serial TX line among N_REQ byte requesters with
//                round-robin arbitration and sequences the shared baud tick
//                generator (baud_en out, baud_tick in). Frames are 8N1,
//                LSB first, with optional even parity and optional idle gap.
//  Revision    : 1.0  initial release
//  Config      : UART_TX_SCHED_PARITY_EN  defined -> even-parity bit after
//                bit 7 (11 bit-times per frame); undefined -> 10 bit-times.
//  Ports       : clk        in  1              system clock
//                rst_n      in  1              async active-low reset
//                req        in  N_REQ          level request, held until ack
//                data       in  N_REQ*DATA_W   packed bytes, slice i per req i
//                ack        out N_REQ          one-hot 1-cycle latch pulse
//                baud_en    out 1              tick generator enable
//                baud_tick  in  1              one pulse per bit period
//                txd        out 1              serial line, idle high
//                busy       out 1              grant through end of stop/gap
//                owner      out IDX_W          current/last granted index
// ============================================================================
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int GAP_TICKS = 0,
  localparam int IDX_W    = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  output logic [N_REQ-1:0]        ack,
  output logic                    baud_en,
  input  logic                    baud_tick,
  output logic                    txd,
  output logic                    busy,
  output logic [IDX_W-1:0]        owner
);

  localparam logic [1:0] GAP_LAST = 2'((GAP_TICKS > 0) ? (GAP_TICKS - 1) : 0);

  state_e             state_q,  state_d;
  logic [BYTE_W-1:0]  shift_q,  shift_d;
  logic [2:0]         bitcnt_q, bitcnt_d;
  logic [1:0]         gapcnt_q, gapcnt_d;
  logic [IDX_W-1:0]   ptr_q,    ptr_d;
  logic [IDX_W-1:0]   owner_q,  owner_d;
  logic [N_REQ-1:0]   ack_q,    ack_d;
  logic               txd_q,    txd_d;
  logic               baud_en_q, baud_en_d;
  logic               busy_q,   busy_d;
`ifdef UART_TX_SCHED_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic [N_REQ-1:0]   w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_grant_valid;
  logic               w_tick;
  logic [IDX_W-1:0]   w_ptr_next;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .valid     (w_grant_valid)
  );

  // A stray tick while the generator is disabled must not advance the frame.
  assign w_tick     = baud_tick & baud_en_q;
  assign w_ptr_next = (w_grant_idx == IDX_W'(N_REQ - 1)) ? '0
                                                         : w_grant_idx + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    gapcnt_d  = gapcnt_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    ack_d     = '0;
    txd_d     = txd_q;
    baud_en_d = baud_en_q;
    busy_d    = busy_q;
`ifdef UART_TX_SCHED_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        txd_d     = 1'b1;
        baud_en_d = 1'b0;
        busy_d    = 1'b0;
        if (w_grant_valid) begin
          ack_d     = w_grant;
          shift_d   = data[int'(w_grant_idx)*DATA_W +: BYTE_W];
          owner_d   = w_grant_idx;
          ptr_d     = w_ptr_next;
          txd_d     = 1'b0;
          baud_en_d = 1'b1;
          busy_d    = 1'b1;
          bitcnt_d  = 3'd0;
          gapcnt_d  = 2'd0;
`ifdef UART_TX_SCHED_PARITY_EN
          parity_d  = 1'b0;
`endif
          state_d   = START;
        end
      end

      START: begin
        if (w_tick) begin
          txd_d    = shift_q[0];
          bitcnt_d = 3'd0;
          state_d  = DATA;
        end
      end

      DATA: begin
        if (w_tick) begin
          if (bitcnt_q == 3'd7) begin
`ifdef UART_TX_SCHED_PARITY_EN
            // Running parity already covers bits 0..6; fold in bit 7 now.
            txd_d   = parity_q ^ shift_q[0];
            state_d = PARITY;
`else
            txd_d   = 1'b1;
            state_d = STOP;
`endif
          end else begin
`ifdef UART_TX_SCHED_PARITY_EN
            parity_d = parity_q ^ shift_q[0];
`endif
            shift_d  = shift_q >> 1;
            txd_d    = shift_q[1];
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end

`ifdef UART_TX_SCHED_PARITY_EN
      PARITY: begin
        if (w_tick) begin
          txd_d   = 1'b1;
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        if (w_tick) begin
          if (GAP_TICKS > 0) begin
            gapcnt_d = 2'd0;
            state_d  = GAP;
          end else begin
            baud_en_d = 1'b0;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end
        end
      end

      GAP: begin
        txd_d = 1'b1;
        if (w_tick) begin
          if (gapcnt_q == GAP_LAST) begin
            baud_en_d = 1'b0;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end else begin
            gapcnt_d = gapcnt_q + 2'd1;
          end
        end
      end

      default: begin
        txd_d     = 1'b1;
        baud_en_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      gapcnt_q  <= '0;
      ptr_q     <= '0;
      owner_q   <= '0;
      ack_q     <= '0;
      txd_q     <= 1'b1;
      baud_en_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_TX_SCHED_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      gapcnt_q  <= gapcnt_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      ack_q     <= ack_d;
      txd_q     <= txd_d;
      baud_en_q <= baud_en_d;
      busy_q    <= busy_d;
`ifdef UART_TX_SCHED_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign ack     = ack_q;
  assign baud_en = baud_en_q;
  assign txd     = txd_q;
  assign busy    = busy_q;
  assign owner   = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_sched
//  Description : Directed self-checking bench for uart_tx_sched. Two
//                instances: default (GAP_TICKS=0) and GAP_TICKS=2. A small
//                tick generator model per instance preloads while disabled
//                and pulses once every BIT clocks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_sched;

  localparam int BIT = 8;
`ifdef UART_TX_SCHED_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic        baud_en;
  logic        baud_tick;
  logic        txd;
  logic        busy;
  logic [1:0]  owner;

  logic [3:0]  req_g;
  logic [31:0] data_g;
  logic [3:0]  ack_g;
  logic        baud_en_g;
  logic        baud_tick_g;
  logic        txd_g;
  logic        busy_g;
  logic [1:0]  owner_g;

  logic        force_tick;
  logic [3:0]  cnt0, cnt_g;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_sched #(.N_REQ(4), .DATA_W(8), .GAP_TICKS(0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .ack(ack),
    .baud_en(baud_en), .baud_tick(baud_tick), .txd(txd), .busy(busy),
    .owner(owner)
  );

  uart_tx_sched #(.N_REQ(4), .DATA_W(8), .GAP_TICKS(2)) dut_g (
    .clk(clk), .rst_n(rst_n), .req(req_g), .data(data_g), .ack(ack_g),
    .baud_en(baud_en_g), .baud_tick(baud_tick_g), .txd(txd_g), .busy(busy_g),
    .owner(owner_g)
  );

  // Tick generator models: counter held at zero while disabled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt0 <= '0;
    else if (!baud_en) cnt0 <= '0;
    else               cnt0 <= (cnt0 == 4'(BIT - 1)) ? 4'd0 : cnt0 + 4'd1;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt_g <= '0;
    else if (!baud_en_g) cnt_g <= '0;
    else                 cnt_g <= (cnt_g == 4'(BIT - 1)) ? 4'd0 : cnt_g + 4'd1;
  end
  assign baud_tick   = force_tick | (baud_en & (cnt0 == 4'(BIT - 1)));
  assign baud_tick_g = baud_en_g & (cnt_g == 4'(BIT - 1));

  function automatic logic [10:0] exp_frame(input logic [7:0] d);
`ifdef UART_TX_SCHED_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge where ack is first seen (or after maxc cycles).
  task automatic wait_ack(input int maxc, output int idx, output int lat);
    lat = 0;
    idx = -1;
    do begin
      @(negedge clk);
      lat++;
    end while (ack == 4'd0 && lat < maxc);
    if (ack == 4'd0) begin
      chk("ack_timeout", 32'd0, 32'd1);
    end else begin
      chk("ack_onehot", 32'($onehot(ack)), 32'd1);
      for (int i = 0; i < 4; i++) if (ack[i]) idx = i;
    end
  endtask

  // Called at the ack negedge; samples each bit mid-period and checks that
  // busy drops exactly NBITS*BIT clocks after the grant edge.
  task automatic get_frame(output logic [10:0] f);
    f = '0;
    @(negedge clk);
    chk("ack_pulse_len", 32'(ack), 32'd0);
    repeat (BIT/2 - 1) @(negedge clk);
    for (int k = 0; k < NBITS; k++) begin
      f[k] = txd;
      if (k < NBITS - 1) repeat (BIT) @(negedge clk);
    end
    repeat (BIT/2 - 1) @(negedge clk);
    chk("busy_last_cycle", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_dropped", 32'(busy), 32'd0);
    chk("baud_en_dropped", 32'(baud_en), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int          idx, lat;
    logic [10:0] f;
    logic [12:0] fg;
    logic        ok;
    int          exp_order [3];

    rst_n = 1'b0; req = '0; data = '0; req_g = '0; data_g = '0; force_tick = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_baud_en", 32'(baud_en), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester, 0x55
    data[7:0] = 8'h55;
    req = 4'b0001;
    wait_ack(400, idx, lat);
    chk("t1_idx", 32'(idx), 32'd0);
    chk("t1_latency", 32'(lat), 32'd1);
    chk("t1_owner", 32'(owner), 32'd0);
    chk("t1_start_bit", 32'(txd), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_baud_en", 32'(baud_en), 32'd1);
    req = 4'b0000;
    get_frame(f);
`ifdef UART_TX_SCHED_PARITY_EN
    chk("t1_frame", 32'(f), 32'h4AA);
`else
    chk("t1_frame", 32'(f), 32'h2AA);
`endif

    // Idle, tick forced high, no request: nothing happens
    force_tick = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (txd !== 1'b1 || ack !== 4'd0 || baud_en !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    force_tick = 1'b0;
    chk("idle_tick_ignored", 32'(ok), 32'd1);

    // Three simultaneous requesters from ptr=0: order 0,1,3
    do_reset();
    data = {8'h3C, 8'h00, 8'h99, 8'hA5};
    req = 4'b1011;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 3;
    for (int i = 0; i < 3; i++) begin
      wait_ack(400, idx, lat);
      chk("t2_idx", 32'(idx), 32'(exp_order[i]));
      chk("t2_owner", 32'(owner), 32'(exp_order[i]));
      chk("t2_gap_one_clk", 32'(lat), 32'd1);
      if (idx >= 0) req[idx] = 1'b0;
      get_frame(f);
      chk("t2_frame", 32'(f), 32'(exp_frame(data[exp_order[i]*8 +: 8])));
    end
    repeat (5) @(negedge clk);
    chk("t2_quiet_ack", 32'(ack), 32'd0);
    chk("t2_quiet_busy", 32'(busy), 32'd0);

    // All four held: strict rotation over 8 frames
    data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      wait_ack(400, idx, lat);
      chk("t3_idx", 32'(idx), 32'(i % 4));
      if (i == 7) req = 4'b0000;
      get_frame(f);
      chk("t3_frame", 32'(f), 32'(exp_frame(data[(i % 4)*8 +: 8])));
    end

    // Parity frame, data 0x07 (three ones -> even parity bit 1)
    data[7:0] = 8'h07;
    req = 4'b0001;
    wait_ack(400, idx, lat);
    chk("t5_idx", 32'(idx), 32'd0);
    req = 4'b0000;
    get_frame(f);
`ifdef UART_TX_SCHED_PARITY_EN
    chk("t5_frame", 32'(f), 32'h60E);
`else
    chk("t5_frame", 32'(f), 32'h20E);
`endif

    // Reset during data bit 4 (data 0x0F -> bit 4 is 0)
    data[7:0] = 8'h0F;
    req = 4'b0001;
    wait_ack(400, idx, lat);
    req = 4'b0000;
    repeat (5*BIT + BIT/2) @(negedge clk);
    chk("t4_bit4_low", 32'(txd), 32'd0);
    chk("t4_busy_pre", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_async_txd", 32'(txd), 32'd1);
    chk("t4_async_baud_en", 32'(baud_en), 32'd0);
    chk("t4_async_busy", 32'(busy), 32'd0);
    chk("t4_async_owner", 32'(owner), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    data[15:8] = 8'h81;
    req = 4'b0010;
    wait_ack(400, idx, lat);
    chk("t4_regrant_idx", 32'(idx), 32'd1);
    chk("t4_regrant_owner", 32'(owner), 32'd1);
    req = 4'b0000;
    get_frame(f);
    chk("t4_frame", 32'(f), 32'(exp_frame(8'h81)));

    // GAP_TICKS=2 instance: two extra mark bit-times before busy drops
    data_g[7:0] = 8'h00;
    req_g = 4'b0001;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ack_g == 4'd0 && lat < 400);
    chk("tg_ack", 32'(ack_g), 32'd1);
    req_g = 4'b0000;
    fg = '0;
    repeat (BIT/2) @(negedge clk);
    for (int k = 0; k < NBITS + 2; k++) begin
      fg[k] = txd_g;
      if (k < NBITS + 1) repeat (BIT) @(negedge clk);
    end
    chk("tg_frame", 32'(fg), 32'((13'h3 << NBITS) | 13'(exp_frame(8'h00))));
    repeat (BIT/2 - 1) @(negedge clk);
    chk("tg_busy_last", 32'(busy_g), 32'd1);
    @(negedge clk);
    chk("tg_busy_dropped", 32'(busy_g), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
